// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-read/multi-write register-file SRAM.
// Holds the init-sequencer state enum and the flat-bus slice helper.
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  // Low bit of lane 'port' in a flat bus packed as {lane[N-1], ..., lane[0]}.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset clear sequencer: walks entries RESET_LO..DEPTH-1, one per cycle,
// then enters READY. The FSM state is exported on state_o for observation.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int INDEX    = $clog2(DEPTH),
  parameter int RESET_LO = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_en,
  output logic [INDEX-1:0]  clr_addr,
  output logic              ready_o,
  output sram_state_e       state_o
);

  localparam bit              SKIP_INIT = (RESET_LO >= DEPTH);
  localparam logic [INDEX-1:0] PTR_START = INDEX'(RESET_LO);
  localparam logic [INDEX-1:0] PTR_LAST  = INDEX'(DEPTH - 1);

  sram_state_e      state_q, state_d;
  logic [INDEX-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKIP_INIT ? READY : INIT;
      ptr_q   <= PTR_START;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    case (state_q)
      INIT: begin
        clr_en = !reset;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = READY;
      end
      default: ;
    endcase
  end

  assign clr_addr = ptr_q;
  // Held low during the reset cycle itself so no write can slip through.
  assign ready_o  = (state_q == READY) && !reset;
  assign state_o  = state_q;

endmodule

// File: rtl/sram_mrnw_pipe.sv
// Parametrised RD_PORTS-read / WR_PORTS-write register file with registered reads,
// post-reset clear, write-collision flag. Optional macro: SRAM_WR_BYPASS_EN.
module sram_mrnw_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int INDEX    = $clog2(DEPTH),
  parameter int WIDTH    = 8,
  parameter int RD_PORTS = 16,
  parameter int WR_PORTS = 8,
  parameter int RESET_LO = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RD_PORTS*INDEX-1:0]  rd_addr_i,
  input  logic [WR_PORTS*INDEX-1:0]  wr_addr_i,
  input  logic [WR_PORTS-1:0]        wr_en_i,
  input  logic [WR_PORTS*WIDTH-1:0]  wr_data_i,
  output logic [RD_PORTS*WIDTH-1:0]  rd_data_o,
  output logic [RD_PORTS*DEPTH-1:0]  rd_dec_o,
  output logic [WR_PORTS*DEPTH-1:0]  wr_dec_o,
  output logic [WR_PORTS-1:0]        we_o,
  output logic                       ready_o,
  output logic                       wr_conflict_o
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [INDEX-1:0] rd_addr [RD_PORTS];
  logic [INDEX-1:0] wr_addr [WR_PORTS];
  logic [WIDTH-1:0] wr_data [WR_PORTS];
  logic [WIDTH-1:0] rd_next [RD_PORTS];

  logic             clr_en;
  logic [INDEX-1:0] clr_addr;
  logic             seq_ready;
  sram_state_e      seq_state;
  logic             conflict_d;

  function automatic logic in_range(input logic [INDEX-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  sram_init_seq #(
    .DEPTH    (DEPTH),
    .INDEX    (INDEX),
    .RESET_LO (RESET_LO)
  ) u_init_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready_o  (seq_ready),
    .state_o  (seq_state)
  );

  assign ready_o = seq_ready;
  assign we_o    = (seq_state == READY && seq_ready) ? wr_en_i : '0;

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) rd_addr[p] = rd_addr_i[slice_lo(p, INDEX) +: INDEX];
    for (int k = 0; k < WR_PORTS; k++) begin
      wr_addr[k] = wr_addr_i[slice_lo(k, INDEX) +: INDEX];
      wr_data[k] = wr_data_i[slice_lo(k, WIDTH) +: WIDTH];
    end
  end

  always_comb begin
    rd_dec_o = '0;
    wr_dec_o = '0;
    for (int p = 0; p < RD_PORTS; p++)
      rd_dec_o[slice_lo(p, DEPTH) +: DEPTH] = DEPTH'(1) << rd_addr[p];
    for (int k = 0; k < WR_PORTS; k++)
      wr_dec_o[slice_lo(k, DEPTH) +: DEPTH] = we_o[k] ? (DEPTH'(1) << wr_addr[k]) : '0;
  end

  // Later ports overwrite earlier ones, so the highest-indexed port wins a collision.
  always_ff @(posedge clk) begin
    if (clr_en) mem[clr_addr] <= '0;
    for (int k = 0; k < WR_PORTS; k++)
      if (we_o[k] && in_range(wr_addr[k])) mem[wr_addr[k]] <= wr_data[k];
  end

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_next[p] = in_range(rd_addr[p]) ? mem[rd_addr[p]] : '0;
`ifdef SRAM_WR_BYPASS_EN
      for (int k = 0; k < WR_PORTS; k++)
        if (we_o[k] && in_range(wr_addr[k]) && wr_addr[k] == rd_addr[p]) rd_next[p] = wr_data[k];
`endif
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int a = 0; a < WR_PORTS; a++)
      for (int b = a + 1; b < WR_PORTS; b++)
        if (we_o[a] && we_o[b] && wr_addr[a] == wr_addr[b]) conflict_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_o     <= '0;
      wr_conflict_o <= 1'b0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) rd_data_o[slice_lo(p, WIDTH) +: WIDTH] <= rd_next[p];
      wr_conflict_o <= conflict_d;
    end
  end

endmodule

// File: doc/sram_mrnw_pipe.md
Name: sram_mrnw_pipe

Overview:
- Parametrised multi-port register-file SRAM with RD_PORTS read ports and WR_PORTS write ports; successor to the fixed 16R8W array.
- Read data is registered (1-cycle latency).
- A post-reset sequencer clears the upper entry range, one entry per cycle.
- Adds write-collision detection and a ready indication.
- Used for rename-map/free-list style storage in the core.

Parameters:
DEPTH, 16, number of entries
INDEX, $clog2(DEPTH), address width (derived; do not override)
WIDTH, 8, entry width in bits
RD_PORTS, 16, number of read ports
WR_PORTS, 8, number of write ports
RESET_LO, 0, first entry cleared after reset; entries below RESET_LO keep their contents

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
rd_addr_i  in  RD_PORTS*INDEX  read addresses; port p at [p*INDEX +: INDEX]
wr_addr_i  in  WR_PORTS*INDEX  write addresses
wr_en_i  in  WR_PORTS  per-port write enable
wr_data_i  in  WR_PORTS*WIDTH  write data
rd_data_o  out  RD_PORTS*WIDTH  registered read data
rd_dec_o  out  RD_PORTS*DEPTH  combinational one-hot decode of each read address
wr_dec_o  out  WR_PORTS*DEPTH  combinational one-hot decode of each write address, gated by the effective enable
we_o  out  WR_PORTS  effective write enable, wr_en_i & ready_o
ready_o  out  1  high when the block is in READY
wr_conflict_o  out  1  registered; high for 1 cycle after a write-address collision

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset.
- FSM states:
  - INIT: clearing entries.
  - READY.
- Reset cycle:
  - state <= INIT and ptr <= RESET_LO.
  - If RESET_LO >= DEPTH, state <= READY directly.
  - rd_data_o <= 0, wr_conflict_o <= 0.
  - ready_o is low while reset is asserted and on the following edge.
  - Reset does not touch entries 0..RESET_LO-1.
- INIT:
  - Each cycle, sram[ptr] <= 0 and ptr <= ptr+1.
  - When ptr == DEPTH-1, the clear completes and state <= READY.
  - INIT lasts exactly DEPTH-RESET_LO cycles.
- Reset asserted mid-INIT: the sequence restarts from RESET_LO.
- Writes:
  - Accepted only in READY. In INIT, we_o = 0 and wr_dec_o = 0, and the array is unaffected except by the clear.
  - On posedge, every port k with we_o[k] writes sram[wr_addr[k]] <= wr_data[k].
  - If ports collide on one address, the highest-indexed port wins.
- Collision flag: wr_conflict_o <= 1 on the next edge if two or more enabled ports share an address in a cycle; otherwise 0.
- Reads:
  - rd_data_o[p] <= sram[rd_addr[p]] on each posedge, in both INIT and READY.
  - Array value is the pre-write content (see Optional Feature).
  - Latency is 1 cycle from address to data.
  - Multiple ports reading the same address is legal.
- Decode outputs:
  - rd_dec_o[p] = 1 << rd_addr[p].
  - wr_dec_o[k] = we_o[k] << wr_addr[k].
- Width rules:
  - Out-of-range addresses (addr >= DEPTH when DEPTH is not a power of 2) must not be generated by users.
  - Such writes are dropped; such reads return 0.

Optional Feature:
- Macro: SRAM_WR_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled write in the same cycle registers that write data instead of the array value.
  - With multiple matches, the highest-indexed port wins, consistent with write priority.
  - Bypass is active only in READY.
- Undefined: reads always return pre-write array content; the bypass mux is absent.

Decomposition:
- Shared package sram_pkg:
  - FSM state enum (INIT, READY).
  - Helper function for flat-bus slice indexing.
- One sub-module, sram_init_seq:
  - Holds the FSM, ptr, and ready_o.
  - Outputs clr_en and clr_addr to the array.
- Array, read registers, collision detect, and bypass stay in the top module.

Test Plan (DEPTH=16, RESET_LO=4, RD_PORTS=4, WR_PORTS=2, WIDTH=8):
- Preload entries 0..3 = 0x10..0x13, then 1-cycle reset -> ready_o low for 12 cycles then high; reads of entries 4..15 return 0x00; entries 0..3 still return 0x10..0x13.
- READY, port0 writes addr 5 = 0xA5; next cycle read addr 5 on port 3 -> rd_data_o[3] = 0xA5 exactly 1 cycle after the address; rd_dec_o[3] = 16'h0020.
- Ports 0 and 1 both write addr 7 with 0x11 and 0x22 -> entry 7 = 0x22; wr_conflict_o = 1 for exactly one cycle, then 0.
- Entry 9 = 0x00; same cycle write 0x3C to addr 9 and read addr 9 -> rd_data_o = 0x00 without SRAM_WR_BYPASS_EN, 0x3C with it; the following read returns 0x3C in both builds.
- During INIT, wr_en_i[0] = 1, addr 2, data 0xFF -> we_o = 0, wr_dec_o = 0; entry 2 unchanged (0x12).
- Reset re-asserted when ptr = 10 -> ptr restarts at 4; ready_o stays low for 12 more cycles; entries 4..15 read 0x00 afterwards.
